// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// A shared radix-2 shift-add multiplier / restoring divider runs XLEN iterations,
// then one sign-fix cycle, then a one-cycle result strobe.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and
// zero-dividend divides skip the iteration phase and return 0 at latency 1.
module muldiv_seq #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      mulDiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [TAGW-1:0] tag_in,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out
);

    localparam int unsigned CNTW = $clog2(XLEN);
    localparam int unsigned PW   = 2 * XLEN;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);

    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_MULH   = 4'b0101;
    localparam logic [3:0] OP_MULHSU = 4'b0110;
    localparam logic [3:0] OP_MULHU  = 4'b0111;
    localparam logic [3:0] OP_DIV    = 4'b1001;
    localparam logic [3:0] OP_DIVU   = 4'b1011;
    localparam logic [3:0] OP_REM    = 4'b1101;
    localparam logic [3:0] OP_REMU   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // product low half / dividend -> quotient
    logic [XLEN-1:0] b_q, b_d;        // |op_b|
    logic [3:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [TAGW-1:0] tag_out_q, tag_out_d;

    // Request decode on the incoming operands
    logic            is_mul_c, is_div_c, is_rem_c, valid_op_c;
    logic            a_signed_c, b_signed_c, sa_c, sb_c;
    logic [XLEN-1:0] abs_a_c, abs_b_c;
    logic            div_zero_c, ovf_c, early_c, special_c, accept_c;
    logic [XLEN-1:0] special_res_c;

    assign is_mul_c   = (mulDiv_op == OP_MUL) || (mulDiv_op == OP_MULH) ||
                        (mulDiv_op == OP_MULHSU) || (mulDiv_op == OP_MULHU);
    assign is_div_c   = (mulDiv_op == OP_DIV) || (mulDiv_op == OP_DIVU) ||
                        (mulDiv_op == OP_REM) || (mulDiv_op == OP_REMU);
    assign is_rem_c   = (mulDiv_op == OP_REM) || (mulDiv_op == OP_REMU);
    assign valid_op_c = is_mul_c || is_div_c;
    assign a_signed_c = (mulDiv_op == OP_MULH) || (mulDiv_op == OP_MULHSU) ||
                        (mulDiv_op == OP_DIV) || (mulDiv_op == OP_REM);
    assign b_signed_c = (mulDiv_op == OP_MULH) || (mulDiv_op == OP_DIV) ||
                        (mulDiv_op == OP_REM);
    assign sa_c       = a_signed_c && op_a[XLEN-1];
    assign sb_c       = b_signed_c && op_b[XLEN-1];
    assign abs_a_c    = sa_c ? (~op_a + XLEN'(1)) : op_a;
    assign abs_b_c    = sb_c ? (~op_b + XLEN'(1)) : op_b;
    assign div_zero_c = is_div_c && (op_b == '0);
    assign ovf_c      = ((mulDiv_op == OP_DIV) || (mulDiv_op == OP_REM)) &&
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_c = (is_mul_c && ((op_a == '0) || (op_b == '0))) ||
                     (is_div_c && (op_a == '0) && (op_b != '0));
`else
    assign early_c = 1'b0;
`endif

    assign special_c = !valid_op_c || div_zero_c || ovf_c || early_c;
    assign accept_c  = start && !kill && (mulDiv_op != 4'b0000) &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));

    // Result for requests that bypass the iteration phase
    always_comb begin
        special_res_c = '0;
        if (div_zero_c) begin
            special_res_c = is_rem_c ? op_a : '1;
        end else if (ovf_c) begin
            special_res_c = is_rem_c ? '0 : op_a;
        end
    end

    // One iteration step of the shared datapath
    logic [XLEN:0]   mul_sum_c;
    logic [XLEN:0]   div_sh_c;
    logic            div_ge_c;
    logic [XLEN-1:0] div_diff_c;

    assign mul_sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_sh_c   = {hi_q, lo_q[XLEN-1]};
    assign div_ge_c   = div_sh_c >= {1'b0, b_q};
    assign div_diff_c = XLEN'(div_sh_c - {1'b0, b_q});

    // Sign correction and result selection applied in FIX
    logic [PW-1:0]   prod_c, prod_fix_c;
    logic [XLEN-1:0] div_sel_c, fix_res_c;

    always_comb begin
        prod_c     = {hi_q, lo_q};
        prod_fix_c = neg_q ? (~prod_c + PW'(1)) : prod_c;
        div_sel_c  = op_q[2] ? hi_q : lo_q;
        if (op_q[3]) begin
            fix_res_c = neg_q ? (~div_sel_c + XLEN'(1)) : div_sel_c;
        end else if (op_q == OP_MUL) begin
            fix_res_c = prod_fix_c[XLEN-1:0];
        end else begin
            fix_res_c = prod_fix_c[PW-1:XLEN];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[3]) begin
                        hi_d = div_ge_c ? div_diff_c : div_sh_c[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], div_ge_c};
                    end else begin
                        {hi_d, lo_d} = {mul_sum_c, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    result_d  = fix_res_c;
                    tag_out_d = tag_q;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_c) begin
            op_d  = mulDiv_op;
            tag_d = tag_in;
            neg_d = (is_div_c && is_rem_c) ? sa_c : (sa_c ^ sb_c);
            b_d   = abs_b_c;
            hi_d  = '0;
            lo_d  = abs_a_c;
            cnt_d = '0;
            if (special_c) begin
                result_d  = special_res_c;
                tag_out_d = tag_in;
                state_d   = S_DONE;
            end else begin
                state_d = S_RUN;
            end
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d  = !ready_d;
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign tag_out      = tag_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (XLEN=32, TAGW=5).
module tb_muldiv_seq;

    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_MULH   = 4'b0101;
    localparam logic [3:0] OP_MULHSU = 4'b0110;
    localparam logic [3:0] OP_MULHU  = 4'b0111;
    localparam logic [3:0] OP_DIV    = 4'b1001;
    localparam logic [3:0] OP_DIVU   = 4'b1011;
    localparam logic [3:0] OP_REM    = 4'b1101;
    localparam logic [3:0] OP_REMU   = 4'b1111;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 34;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  mulDiv_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  tag_in;
    logic        kill;
    logic        ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    muldiv_seq #(.XLEN(32), .TAGW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mulDiv_op    (mulDiv_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .tag_in       (tag_in),
        .kill         (kill),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .tag_out      (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for ready, present one request for exactly the accepting edge
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg);
        int n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        mulDiv_op = op; op_a = a; op_b = b; tag_in = tg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mulDiv_op = 4'b0000;
    endtask

    // Count edges (accepting edge = 1) until result_valid, bounded
    task automatic collect(input int lat0, output logic [31:0] res, output logic [4:0] tg,
                           output int lat);
        lat = lat0;
        while (!result_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = result;
        tg  = tag_out;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg,
                          input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  tgo;
        int          lat;
        launch(op, a, b, tg);
        collect(1, res, tgo, lat);
        check_eq({name, "_res"}, 64'(res), 64'(exp_res));
        check_eq({name, "_tag"}, 64'(tgo), 64'(tg));
        check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    logic [31:0] res;
    logic [4:0]  tgo;
    int          lat;
    logic [31:0] held_res;
    logic [4:0]  held_tag;

    initial begin
        rst_n = 1'b0; start = 1'b0; mulDiv_op = 4'b0000;
        op_a = '0; op_b = '0; tag_in = '0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_valid", 64'(result_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_tag",   64'(tag_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL with pulse-width check
        launch(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9);
        collect(1, res, tgo, lat);
        check_eq("mul_res", 64'(res), 64'hFFFF_FFEB);
        check_eq("mul_tag", 64'(tgo), 64'd9);
        check_eq("mul_lat", 64'(lat), 64'd34);
        @(posedge clk); #1;
        check_eq("mul_pulse", 64'(result_valid), 64'd0);
        check_eq("mul_hold", 64'(result), 64'hFFFF_FFEB);
        check_eq("mul_idle_ready", 64'(ready), 64'd1);

        run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, 34);
        run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 34);
        run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFF, 34);
        run_op("divu",   OP_DIVU,   32'd100,       32'd7,         5'd6, 32'd14,        34);
        run_op("remu",   OP_REMU,   32'd100,       32'd7,         5'd7, 32'd2,         34);
        run_op("divu0",  OP_DIVU,   32'd5,         32'd0,         5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem0",   OP_REM,    32'd5,         32'd0,         5'd10, 32'd5,        1);
        run_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        run_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1);
        run_op("badop",  4'b0001,   32'd3,         32'd4,         5'd13, 32'd0,        1);

        // Opcode 0000 with start is not a request
        mulDiv_op = 4'b0000; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        check_eq("nop_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        check_eq("nop_valid", 64'(result_valid), 64'd0);
        start = 1'b0;

        // Kill at iteration 10
        held_res = result;
        held_tag = tag_out;
        launch(OP_MUL, 32'd123, 32'd456, 5'd14);
        repeat (10) @(posedge clk);
        #1;
        check_eq("kill_busy_before", 64'(busy), 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_eq("kill_ready", 64'(ready), 64'd1);
        check_eq("kill_busy", 64'(busy), 64'd0);
        check_eq("kill_valid", 64'(result_valid), 64'd0);
        check_eq("kill_result", 64'(result), 64'(held_res));
        check_eq("kill_tag", 64'(tag_out), 64'(held_tag));
        run_op("divu93", OP_DIVU, 32'd9, 32'd3, 5'd15, 32'd3, 34);

        // Back-to-back: start held, second request accepted in the DONE cycle
        mulDiv_op = OP_DIVU; op_a = 32'd100; op_b = 32'd7; tag_in = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        mulDiv_op = OP_REMU; tag_in = 5'd17;
        repeat (4) @(posedge clk);
        #1;
        check_eq("b2b_run_busy", 64'(busy), 64'd1);
        collect(5, res, tgo, lat);
        check_eq("b2b1_res", 64'(res), 64'd14);
        check_eq("b2b1_tag", 64'(tgo), 64'd16);
        check_eq("b2b1_lat", 64'(lat), 64'd34);
        check_eq("b2b1_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        start = 1'b0; mulDiv_op = 4'b0000;
        check_eq("b2b2_accept", 64'(busy), 64'd1);
        collect(1, res, tgo, lat);
        check_eq("b2b2_res", 64'(res), 64'd2);
        check_eq("b2b2_tag", 64'(tgo), 64'd17);
        check_eq("b2b2_lat", 64'(lat), 64'd34);

        // Asynchronous reset in the middle of RUN
        launch(OP_MUL, 32'd5, 32'd6, 5'd18);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 64'(ready), 64'd1);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_valid", 64'(result_valid), 64'd0);
        check_eq("arst_result", 64'(result), 64'd0);
        check_eq("arst_tag", 64'(tag_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_novalid", 64'(result_valid), 64'd0);

        // Zero operands: latency depends on the early-out build option
        run_op("mulz", OP_MUL, 32'd0, 32'd5, 5'd19, 32'd0, ZERO_LAT);
        run_op("divz", OP_DIV, 32'd0, 32'd7, 5'd20, 32'd0, ZERO_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
